// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// Nothing in this file depends on the DMEM_PERF_CNT_EN build option.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      SZ_W:    return |lane[1:0];
      default: return |lane;
    endcase
  endfunction

  // Byte-enable pattern for an access of the given size at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Load formatter: pulls the addressed lane out of a 64-bit RAM word and
// sign- or zero-extends it according to the load funct3.
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  lane,
  input  logic [2:0]  func3,
  output logic [63:0] data
);

  logic [63:0] shifted;

  assign shifted = word >> {lane, 3'b000};

  always_comb begin
    data = '0;
    case (func3)
      F3_LB:  data = {{56{shifted[7]}}, shifted[7:0]};
      F3_LH:  data = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:  data = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:  data = shifted;
      F3_LBU: data = {56'd0, shifted[7:0]};
      F3_LHU: data = {48'd0, shifted[15:0]};
      F3_LWU: data = {32'd0, shifted[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, backed by a
// 64-bit synchronous RAM. Define DMEM_PERF_CNT_EN to build the completion counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 512,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_re,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt,
  output logic [31:0] err_cnt
);

  logic [1:0]       state;
  logic [63:0]      mem [DEPTH_WORDS];
  logic [63:0]      rd_word;
  logic [2:0]       lane_q;
  logic [2:0]       func3_q;
  logic [63:0]      load_data;

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [2:0]       lane;
  logic [1:0]       size;
  logic             is_load;
  logic             is_store;
  logic             store_f3_ok;
  logic             req_err;
  logic             do_load;
  logic             do_store;
  logic [7:0]       be;
  logic [63:0]      wshift;
  logic             unused_addr_bits;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;

  // Upper address bits are deliberately dropped so the RAM aliases.
  assign idx              = req_addr[3 +: IDX_W];
  assign unused_addr_bits = ^req_addr[63:3+IDX_W];
  assign lane             = req_addr[2:0];
  assign size             = req_func3[1:0];

  assign is_load     = req_re && !req_we;
  assign is_store    = req_we && !req_re;
  assign store_f3_ok = (req_func3 == F3_SB) || (req_func3 == F3_SH) ||
                       (req_func3 == F3_SW) || (req_func3 == F3_SD);
  assign req_err     = (req_we && req_re) ||
                       ((req_we || req_re) && misaligned(size, lane)) ||
                       (is_load && (req_func3 == 3'b111)) ||
                       (is_store && !store_f3_ok);
  assign do_load     = accept && is_load && !req_err;
  assign do_store    = accept && is_store && !req_err;

  assign be     = size_mask(size) << lane;
  assign wshift = req_wdata << {lane, 3'b000};

  // RAM port: not reset, so a store committed in its accept cycle survives a reset.
  always_ff @(posedge clk) begin
    if (do_load) begin
      rd_word <= mem[idx];
    end
    if (do_store) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wshift[8*b +: 8];
        end
      end
    end
  end

  dmem_load_fmt u_load_fmt (
    .word  (rd_word),
    .lane  (lane_q),
    .func3 (func3_q),
    .data  (load_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lane_q    <= '0;
      func3_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lane_q    <= lane;
            func3_q   <= req_func3;
            rsp_rdata <= '0;
            rsp_err   <= req_err;
            state     <= do_load ? ST_RD : ST_RESP;
          end
        end
        ST_RD: begin
          rsp_rdata <= load_data;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_PERF_CNT_EN
  logic was_load;
  logic was_store;

  // Count on the response handshake; errors take precedence over the kind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      was_load  <= 1'b0;
      was_store <= 1'b0;
      load_cnt  <= '0;
      store_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (accept) begin
        was_load  <= is_load;
        was_store <= is_store;
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_err) begin
          err_cnt <= err_cnt + 32'd1;
        end else if (was_load) begin
          load_cnt <= load_cnt + 32'd1;
        end else if (was_store) begin
          store_cnt <= store_cnt + 32'd1;
        end
      end
    end
  end
`else
  assign load_cnt  = '0;
  assign store_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a byte-level memory model drives the
// expected responses, with literal expectations pinning the key results.
module tb_dmem_responder;

`ifdef DMEM_PERF_CNT_EN
  localparam logic PERF = 1'b1;
`else
  localparam logic PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_re;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;
  logic [31:0] err_cnt;

  int tests = 0;
  int fails = 0;

  // Byte-addressed model of the 512 x 8-byte RAM (4096 bytes, wrapping).
  logic [7:0]  mbytes [4096];
  int          n_load, n_store, n_err;
  logic        exp_pending;
  logic [63:0] exp_rdata;
  logic        exp_err;

  logic [63:0] rd;
  logic        er;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_re    (req_re),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_func3 (req_func3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .load_cnt  (load_cnt),
    .store_cnt (store_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%016h, required 0x%016h", name, act, req);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return 32'(n) & {32{PERF}};
  endfunction

  // Architectural view of one request: kind 0 no-op, 1 load, 2 store, 3 error.
  task automatic model_access(input logic we, input logic re, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [2:0] f3,
                              output logic [63:0] mrd, output logic mer, output int kind);
    int n;
    logic [11:0] base;
    logic [63:0] ones;
    logic mis;
    n    = 1 << f3[1:0];
    base = addr[11:0];
    mis  = (int'(addr[2:0]) % n) != 0;
    mrd  = '0;
    mer  = 1'b0;
    kind = 0;
    if (we && re)  mer = 1'b1;
    else if (we)   mer = mis || f3[2];
    else if (re)   mer = mis || (f3 == 3'b111);
    if (mer) begin
      kind = 3;
    end else if (we) begin
      kind = 2;
      for (int i = 0; i < n; i++) mbytes[base + 12'(i)] = wdata[8*i +: 8];
    end else if (re) begin
      kind = 1;
      for (int i = 0; i < n; i++) mrd[8*i +: 8] = mbytes[base + 12'(i)];
      if (!f3[2] && mrd[8*n-1]) begin
        ones = '1;
        mrd  = mrd | (ones << (8*n));
      end
    end
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [2:0] f3, input int hold,
                               output logic [63:0] ord, output logic oer);
    logic [63:0] mrd;
    logic        mer;
    int          kind;
    int          lat;
    int          exp_lat;
    bit          seen;
    ord = '0;
    oer = 1'b0;
    checkOutput("req_ready before accept", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_re    = re;
    req_addr  = addr;
    req_wdata = wdata;
    req_func3 = f3;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_re    = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_func3 = 3'($urandom);
    model_access(we, re, addr, wdata, f3, mrd, mer, kind);
    exp_rdata   = mrd;
    exp_err     = mer;
    exp_pending = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    if (!seen) begin
      checkOutput("response timeout", rsp_valid, 1);
      exp_pending = 1'b0;
      rsp_ready   = 1'b0;
      return;
    end
    exp_lat = (re && !we && !mer) ? 2 : 1;
    checkOutput("response latency", lat, exp_lat);
    ord = rsp_rdata;
    oer = rsp_err;
    if (hold > 0) begin
      // A competing store must be ignored while the response is pending.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_re    = 1'b0;
      req_addr  = 64'h10;
      req_wdata = 64'h0;
      req_func3 = 3'b011;
      repeat (hold) @(negedge clk);
      req_valid = 1'b0;
      checkOutput("rsp_valid held", rsp_valid, 1);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_pending = 1'b0;
    rsp_ready   = 1'b0;
    case (kind)
      1: n_load++;
      2: n_store++;
      3: n_err++;
      default: ;
    endcase
    checkOutput("rsp_valid after handshake", rsp_valid, 0);
    checkOutput("req_ready after handshake", req_ready, 1);
  endtask

  // Cycle-by-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (rsp_valid) begin
          checkOutput("rsp_valid expected", rsp_valid, exp_pending);
          if (exp_pending) begin
            checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
            checkOutput("rsp_err", rsp_err, exp_err);
            checkOutput("req_ready while busy", req_ready, 0);
          end
        end
        checkOutput("load_cnt", load_cnt, exp_cnt(n_load));
        checkOutput("store_cnt", store_cnt, exp_cnt(n_store));
        checkOutput("err_cnt", err_cnt, exp_cnt(n_err));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mbytes[i] = 8'h00;
    n_load = 0; n_store = 0; n_err = 0;
    exp_pending = 1'b0;
    exp_rdata   = '0;
    exp_err     = 1'b0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_re    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_func3 = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset req_ready", req_ready, 1);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset rsp_rdata", rsp_rdata, 0);
    checkOutput("reset rsp_err", rsp_err, 0);
    checkOutput("reset err_cnt", err_cnt, 0);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(1, 0, 64'h10, 64'h1122334455667788, 3'b011, 0, rd, er);
    checkOutput("SD ack err", er, 0);
    checkOutput("SD ack rdata", rd, 0);
    applyStimulus(0, 1, 64'h10, 64'h0, 3'b011, 0, rd, er);
    checkOutput("LD 0x10", rd, 64'h1122334455667788);

    applyStimulus(1, 0, 64'h13, 64'h80, 3'b000, 0, rd, er);
    applyStimulus(0, 1, 64'h13, 64'h0, 3'b000, 0, rd, er);
    checkOutput("LB 0x13", rd, 64'hFFFFFFFFFFFFFF80);
    applyStimulus(0, 1, 64'h13, 64'h0, 3'b100, 0, rd, er);
    checkOutput("LBU 0x13", rd, 64'h0000000000000080);
    applyStimulus(0, 1, 64'h10, 64'h0, 3'b011, 0, rd, er);
    checkOutput("LD 0x10 after SB", rd, 64'h1122334480667788);
    applyStimulus(0, 1, 64'h12, 64'h0, 3'b001, 0, rd, er);
    checkOutput("LH 0x12", rd, 64'hFFFFFFFFFFFF8066);
    applyStimulus(0, 1, 64'h14, 64'h0, 3'b010, 0, rd, er);
    applyStimulus(0, 1, 64'h10, 64'h0, 3'b110, 0, rd, er);
    checkOutput("LWU 0x10", rd, 64'h0000000080667788);

    applyStimulus(1, 0, 64'h20, 64'hCAFEF00DDEADBEEF, 3'b011, 0, rd, er);
    applyStimulus(0, 1, 64'h12, 64'h0, 3'b010, 0, rd, er);
    checkOutput("LW 0x12 err", er, 1);
    checkOutput("LW 0x12 rdata", rd, 0);
    applyStimulus(1, 0, 64'h21, 64'hFFFF, 3'b001, 0, rd, er);
    checkOutput("SH 0x21 err", er, 1);
    applyStimulus(0, 1, 64'h20, 64'h0, 3'b011, 0, rd, er);
    checkOutput("LD 0x20 unchanged", rd, 64'hCAFEF00DDEADBEEF);
`ifdef DMEM_PERF_CNT_EN
    checkOutput("err_cnt after two errors", err_cnt, 2);
`endif

    applyStimulus(0, 1, 64'h10, 64'h0, 3'b111, 0, rd, er);
    applyStimulus(1, 1, 64'h10, 64'h55, 3'b011, 0, rd, er);
    applyStimulus(1, 0, 64'h28, 64'h77, 3'b100, 0, rd, er);
    applyStimulus(0, 0, 64'h30, 64'h99, 3'b011, 0, rd, er);
    checkOutput("no-op err", er, 0);

    applyStimulus(1, 0, 64'h18, 64'hFFFFFFFFFFFFFFFF, 3'b011, 0, rd, er);
    applyStimulus(1, 0, 64'h1C, 64'h0, 3'b010, 0, rd, er);
    applyStimulus(0, 1, 64'h18, 64'h0, 3'b011, 0, rd, er);
    checkOutput("LD after SW", rd, 64'h00000000FFFFFFFF);
    applyStimulus(1, 0, 64'h1A, 64'hABCD, 3'b001, 0, rd, er);
    applyStimulus(0, 1, 64'h1A, 64'h0, 3'b101, 0, rd, er);
    checkOutput("LHU 0x1A", rd, 64'h000000000000ABCD);

    applyStimulus(0, 1, 64'h10, 64'h0, 3'b011, 5, rd, er);
    checkOutput("LD held response", rd, 64'h1122334480667788);
    applyStimulus(0, 1, 64'h10, 64'h0, 3'b011, 0, rd, er);

    applyStimulus(1, 0, 64'h1000, 64'hAA, 3'b011, 0, rd, er);
    applyStimulus(0, 1, 64'h0, 64'h0, 3'b011, 0, rd, er);
    checkOutput("LD wrap 0x0", rd, 64'hAA);

    // Reset while a load is in RD.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_re    = 1'b1;
    req_addr  = 64'h10;
    req_func3 = 3'b011;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset_n   = 1'b0;
    n_load = 0; n_store = 0; n_err = 0;
    @(negedge clk);
    checkOutput("mid-reset rsp_valid", rsp_valid, 0);
    checkOutput("mid-reset req_ready", req_ready, 1);
    checkOutput("mid-reset load_cnt", load_cnt, 0);
    checkOutput("mid-reset store_cnt", store_cnt, 0);
    checkOutput("mid-reset err_cnt", err_cnt, 0);
    reset_n   = 1'b1;
    rsp_ready = 1'b0;
    @(negedge clk);
    applyStimulus(0, 1, 64'h10, 64'h0, 3'b011, 0, rd, er);
    checkOutput("LD after reset", rd, 64'h1122334480667788);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the core's load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake, backed by a 64-bit-wide synchronous RAM.
- Performs byte/half/word/double access selected by func3, with RISC-V little-endian lane alignment and sign/zero extension.
- Returns either an ack or load data, plus an error flag for illegal or misaligned accesses.
- Replaces the combinational single-cycle data memory when the core moves to a multi-cycle or pipelined memory stage.

Parameters:
- DEPTH_WORDS, 512, number of 64-bit RAM words; must be a power of two.
- IDX_W, $clog2(DEPTH_WORDS), RAM index width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  store request.
- req_re  in  1  load request.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-justified.
- req_func3  in  3  RISC-V funct3 of the load/store.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  64  extended load data; 0 for stores and errors.
- rsp_err  out  1  access was illegal or misaligned.
- load_cnt  out  32  loads completed (see Optional Feature).
- store_cnt  out  32  stores completed.
- err_cnt  out  32  errored requests.

Behaviour:
- Reset (asynchronous, reset_n low):
  - State = IDLE.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - All counters = 0.
  - RAM contents are not reset.
- Reset mid-operation:
  - Any in-flight response is dropped.
  - A store already written in its accept cycle remains in RAM.
- Accept: request is accepted when req_valid && req_ready. req_ready = 1 only in IDLE.
- Addressing:
  - RAM index = req_addr[3 +: IDX_W]; upper address bits are ignored, so addresses wrap.
  - Byte lane = req_addr[2:0].
- Access size = req_func3[1:0]: 00 byte, 01 half, 10 word, 11 double.
- Misalignment: when the low address bits are nonzero for the size (half: addr[0]; word: addr[1:0]; double: addr[2:0]).
- Error cases:
  - Misaligned access.
  - Both req_we and req_re set.
  - Load with func3 = 111.
  - Store with func3[2] = 1.
  - On error: no RAM write occurs.
- No-op: if neither req_we nor req_re is set, the request is acked with err = 0 and rdata = 0.
- FSM states: IDLE, RD, RESP.
  - IDLE, accepting a legal load: issue RAM read → RD.
  - IDLE, accepting a legal store: write RAM with byte enables (req_wdata shifted to the lane) → RESP.
  - IDLE, accepting an error or no-op: → RESP with rsp_err set as above.
  - RD: RAM data valid; extract the lane, extend (func3[2] = 0 sign-extend, 1 zero-extend), register into rsp_rdata → RESP.
  - RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid && rsp_ready → IDLE.
- Latency:
  - Load: rsp_valid is asserted 2 cycles after the accept edge.
  - Store, error, no-op: 1 cycle after the accept edge.
  - Best-case throughput: one store per 2 cycles, one load per 3 cycles.
- Request inputs are sampled only on the accept edge; changes afterwards have no effect.
- Read-after-write: a load accepted the cycle after a store's response handshake sees the stored data.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined:
  - load_cnt, store_cnt and err_cnt each increment by 1 on the response handshake of the matching kind.
  - Counters wrap modulo 2^32.
  - No-ops are not counted.
- Undefined: all three ports are tied to 0 and no counter flops are instantiated. Ports are always present.

Decomposition:
- Package dmem_pkg holds:
  - funct3 encodings (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD).
  - Size codes.
  - FSM state enum.
  - Misalignment function.
- Sub-module dmem_load_fmt: combinational lane extract plus sign/zero extend (inputs: 64-bit word, addr[2:0], func3; output: 64-bit data). The store-side byte-enable and shift logic stays in the top module.

Test Plan:
- SD 0x1122334455667788 @0x10, then LD @0x10 → store ack err = 0 after 1 cycle; load rsp_rdata = 0x1122334455667788, 2 cycles after accept.
- SB 0x80 @0x13, then LB @0x13 and LBU @0x13 → LB = 0xFFFFFFFFFFFFFF80, LBU = 0x0000000000000080; LD @0x10 = 0x1122334480667788.
- LW @0x12 and SH @0x21 → rsp_err = 1, rsp_rdata = 0, RAM word at 0x20 unchanged; err_cnt = 2 with DMEM_PERF_CNT_EN defined.
- Hold rsp_ready = 0 for 5 cycles after a load → rsp_valid, rsp_rdata and rsp_err stay stable, req_ready = 0; a new req_valid is ignored until the handshake completes.
- Assert reset_n = 0 during RD of a load → next edge: rsp_valid = 0, req_ready = 1, counters = 0; a subsequent LD returns the previously stored RAM data.
- DEPTH_WORDS = 512, SD 0xAA @0x1000 → LD @0x0 returns 0xAA (address wrap).
